// File: rtl/led_serializer_pkg.sv
// rtl/led_serializer_pkg.sv - shared constants, state encoding and width helper for the LED serializer
package led_ser_pkg;

    localparam int LED_WIDTH          = 16;
    localparam int DEF_CLK_DIV        = 4;
    localparam int DEF_REFRESH_CYCLES = 1000000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    // Bits needed to count 0..count-1, never less than one bit.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/led_serializer_if.sv
// rtl/led_serializer_if.sv - pattern input / serial chain output bundle for the LED serializer
interface led_ser_if;
    import led_ser_pkg::*;

    logic [LED_WIDTH-1:0] led_in;
    logic                 enable;
    logic                 sclk;
    logic                 sdata;
    logic                 latch;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output led_in, enable,
        input  sclk, sdata, latch, busy, frame_done
    );

    modport slave (
        input  led_in, enable,
        output sclk, sdata, latch, busy, frame_done
    );

endinterface

// File: rtl/led_serializer_tick.sv
// rtl/led_serializer_tick.sv - CLK_DIV phase divider with clear and one-cycle phase-end strobe
module led_ser_tick
    import led_ser_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic phase_end
);

    localparam int              DW       = cnt_width(CLK_DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // The last cycle of each phase; suppressed while held clear so IDLE never strobes.
    assign phase_end = !clear && (div_cnt == DIV_LAST);

    // Free-running phase counter, parked at zero while cleared and wrapped at each phase end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clear || phase_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_serializer.sv
// rtl/led_serializer.sv - 16-bit LED pattern serializer to an external shift-register chain (option: LED_SER_REFRESH_EN)
module led_serializer
    import led_ser_pkg::*;
#(
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic      clk,
    input  logic      rst_n,
    led_ser_if.slave  bus
);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("led_serializer: CLK_DIV must be 1..255");
    end
    if (REFRESH_CYCLES < 1) begin : g_bad_refresh
        $error("led_serializer: REFRESH_CYCLES must be at least 1");
    end

    localparam logic [3:0] LAST_BIT = 4'(LED_WIDTH - 1);

    state_t                state, state_nx;
    logic [LED_WIDTH-1:0]  shreg, shreg_nx;
    logic [LED_WIDTH-1:0]  word, word_nx;
    logic [LED_WIDTH-1:0]  last_sent, last_sent_nx;
    logic [3:0]            bit_cnt, bit_cnt_nx;
    logic                  pending, pending_nx;
    logic                  sdata_q, sdata_nx;
    logic                  frame_done_q, frame_done_nx;
    logic                  sclk_q, latch_q, busy_q;
    logic                  phase_end;
    logic                  refresh_hit;
    logic                  start;

    led_ser_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == IDLE),
        .phase_end (phase_end)
    );

`ifdef LED_SER_REFRESH_EN
    localparam int            RW      = cnt_width(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] idle_cnt;

    assign refresh_hit = (idle_cnt == REF_MAX);

    // Counts IDLE cycles since the last frame; saturates so a refresh waits for enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state != IDLE || start) begin
            idle_cnt <= '0;
        end else if (!refresh_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // Only the value present while idle matters; anything seen mid-frame is simply re-compared later.
    assign start = (state == IDLE) && bus.enable &&
                   (pending || (bus.led_in != last_sent) || refresh_hit);

    // Next-state and datapath decisions for the frame sequencer.
    always_comb begin
        state_nx      = state;
        shreg_nx      = shreg;
        word_nx       = word;
        last_sent_nx  = last_sent;
        bit_cnt_nx    = bit_cnt;
        pending_nx    = pending;
        sdata_nx      = sdata_q;
        frame_done_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nx   = bus.led_in;
                    word_nx    = bus.led_in;
                    sdata_nx   = bus.led_in[LED_WIDTH-1];
                    bit_cnt_nx = '0;
                    pending_nx = 1'b0;
                    state_nx   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_nx = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    if (bit_cnt != LAST_BIT) begin
                        shreg_nx   = shreg << 1;
                        sdata_nx   = shreg[LED_WIDTH-2];
                        bit_cnt_nx = bit_cnt + 1'b1;
                        state_nx   = SHIFT_LO;
                    end else begin
                        state_nx = LATCH;
                    end
                end
            end
            LATCH: begin
                if (phase_end) begin
                    last_sent_nx  = word;
                    frame_done_nx = 1'b1;
                    state_nx      = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any frame without a latch strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            word         <= '0;
            last_sent    <= '0;
            bit_cnt      <= '0;
            pending      <= 1'b1;
            sdata_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sclk_q       <= 1'b0;
            latch_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nx;
            shreg        <= shreg_nx;
            word         <= word_nx;
            last_sent    <= last_sent_nx;
            bit_cnt      <= bit_cnt_nx;
            pending      <= pending_nx;
            sdata_q      <= sdata_nx;
            frame_done_q <= frame_done_nx;
            sclk_q       <= (state_nx == SHIFT_HI);
            latch_q      <= (state_nx == LATCH);
            busy_q       <= (state_nx != IDLE);
        end
    end

    assign bus.sclk       = sclk_q;
    assign bus.sdata      = sdata_q;
    assign bus.latch      = latch_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule
